memoreer: RTL

Load/store functional unit for the c16 pipeline, and the data-side counterpart of the instruction fetcher: where the fetcher only reads program RAM, this unit issues both reads and writes to data RAM. It accepts one memory op at a time from the issue/scoreboard stage over a valid/ready handshake. It drives a synchronous single-port RAM with one-cycle read latency and returns load results to register writeback over a second valid/ready handshake.

---
 rtl/c16_pkg.sv | 22 ++
 rtl/memoreer_fwd_entry.sv | 36 +++
 rtl/memoreer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/c16_pkg.sv
// Shared c16 definitions: memory opcodes, the default data width and the
// load/store unit state encoding.
package c16_pkg;

  localparam int C16_DATA_W = 16;

  localparam logic [3:0] DO_LOAD  = 4'h2;
  localparam logic [3:0] DO_STORE = 4'h3;

  typedef enum logic [2:0] {
    MS_IDLE,
    MS_STORE,
    MS_LOAD,
    MS_CAPT,
    MS_RESP
  } memoreer_state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == DO_LOAD) || (op == DO_STORE);
  endfunction

endpackage

// File: rtl/memoreer_fwd_entry.sv
// One-entry store forwarding register {valid, addr, data}.
// Only instantiated when MEMOREER_FWD_EN is defined.
module memoreer_fwd_entry #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              vld;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld    <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (wr_en) begin
      vld    <= 1'b1;
      addr_q <= wr_addr;
      data_q <= wr_data;
    end
  end

  assign hit      = vld && (addr_q == lookup_addr);
  assign hit_data = data_q;

endmodule

// File: rtl/memoreer.sv
// c16 load/store unit: one op at a time into a single-port sync RAM.
// Optional store-to-load forwarding is enabled by defining MEMOREER_FWD_EN.
//
// state    | meaning
// IDLE     | ready for a new op
// STORE    | write strobe to RAM
// LOAD     | read strobe to RAM
// CAPT     | RAM data valid, capture into writeback regs
// RESP     | result offered to writeback
module memoreer
  import c16_pkg::*;
#(
  parameter int DATA_W = C16_DATA_W,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_op,
  input  logic [DATA_W-1:0] issue_base,
  input  logic [DATA_W-1:0] issue_offset,
  input  logic [DATA_W-1:0] issue_data,
  input  logic [2:0]        issue_dest,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [2:0]        wb_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic              store_done,
  output logic              op_err,
  output logic              busy
);

  memoreer_state_t   state, state_nxt;
  logic              accept;
  logic [DATA_W-1:0] eff;
  logic [ADDR_W-1:0] eff_addr;
  logic [2:0]        dest_q;
  logic              err_q;
  logic              fwd_hit;

  assign accept   = issue_valid && (state == MS_IDLE);
  assign eff      = issue_base + issue_offset;
  assign eff_addr = ADDR_W'(eff);

`ifdef MEMOREER_FWD_EN
  logic [DATA_W-1:0] fwd_data;

  // mem_addr/mem_wdata hold the store's address and data while in STORE
  memoreer_fwd_entry #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fwd (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (state == MS_STORE),
    .wr_addr    (mem_addr),
    .wr_data    (mem_wdata),
    .lookup_addr(eff_addr),
    .hit        (fwd_hit),
    .hit_data   (fwd_data)
  );
`else
  assign fwd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MS_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MS_IDLE: begin
        if (accept) begin
          if (issue_op == DO_STORE)     state_nxt = MS_STORE;
          else if (issue_op == DO_LOAD) state_nxt = fwd_hit ? MS_RESP : MS_LOAD;
        end
      end
      MS_STORE: state_nxt = MS_IDLE;
      MS_LOAD:  state_nxt = MS_CAPT;
      MS_CAPT:  state_nxt = MS_RESP;
      MS_RESP:  if (wb_ready) state_nxt = MS_IDLE;
      default:  state_nxt = MS_IDLE;
    endcase
  end

  always_comb begin
    issue_ready = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    store_done  = 1'b0;
    wb_valid    = 1'b0;
    case (state)
      MS_IDLE:  issue_ready = 1'b1;
      MS_STORE: begin
        mem_we     = 1'b1;
        store_done = 1'b1;
      end
      MS_LOAD:  mem_re = 1'b1;
      MS_RESP:  wb_valid = 1'b1;
      default:  ;
    endcase
  end

  assign busy   = (state != MS_IDLE);
  assign op_err = err_q;

  // Illegal ops leave the address/data registers untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      dest_q    <= '0;
      wb_value  <= '0;
      wb_dest   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= accept && !is_mem_op(issue_op);
      if (accept && is_mem_op(issue_op)) begin
        mem_addr <= eff_addr;
        dest_q   <= issue_dest;
      end
      if (accept && (issue_op == DO_STORE)) mem_wdata <= issue_data;
      if (state == MS_CAPT) begin
        wb_value <= mem_rdata;
        wb_dest  <= dest_q;
      end
`ifdef MEMOREER_FWD_EN
      if (accept && (issue_op == DO_LOAD) && fwd_hit) begin
        wb_value <= fwd_data;
        wb_dest  <= issue_dest;
      end
`endif
    end
  end

endmodule
